uart_frame_tx: RTL and testbench

UART_FRAME_TX -- requirements
Module: uart_frame_tx

---
 rtl/uart_frame_tx.sv | 155 +++++++++++++++
 tb/tb_uart_frame_tx.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_tx.sv
// Frames upstream bytes for a byte-wide UART transmitter: each frame is a
// HEADER_BYTE sync byte followed by FRAME_LEN data bytes drawn from a small FIFO.
module uart_frame_tx #(
    parameter logic [7:0] HEADER_BYTE = 8'hAA,
    parameter int         FRAME_LEN   = 16,
    parameter int         FIFO_DEPTH  = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_s_valid,
    input  logic [7:0] i_s_byte,
    output logic       o_s_ready,
    output logic       o_tx_dv,
    output logic [7:0] o_tx_byte,
    input  logic       i_tx_active,
    input  logic       i_tx_done,
    output logic       o_frame_done,
    output logic       o_busy
);

    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [7:0]  LAST_COUNT = 8'(FRAME_LEN);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SEND_HDR  = 3'd1;
    localparam logic [2:0] WAIT_HDR  = 3'd2;
    localparam logic [2:0] SEND_DATA = 3'd3;
    localparam logic [2:0] WAIT_DATA = 3'd4;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [2:0]    state_q, state_d;
    logic [7:0]    data_cnt_q, data_cnt_d;
    logic          tx_dv_q, tx_dv_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          frame_done_q, frame_done_d;

    logic push;
    logic pop;
    logic fifo_empty;

    // Ready depends only on the registered count, so upstream never sees a
    // combinational path from its own valid or from this cycle's pop.
    assign o_s_ready  = (count_q != FULL_COUNT);
    assign push       = i_s_valid && o_s_ready;
    assign fifo_empty = (count_q == '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_s_byte;
        end
    end

    always_comb begin
        state_d      = state_q;
        data_cnt_d   = data_cnt_q;
        tx_dv_d      = 1'b0;
        tx_byte_d    = tx_byte_q;
        frame_done_d = 1'b0;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !i_tx_active) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = HEADER_BYTE;
                    state_d   = WAIT_HDR;
                end
            end
            SEND_HDR: begin
                if (!i_tx_active) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = HEADER_BYTE;
                    state_d   = WAIT_HDR;
                end
            end
            WAIT_HDR: begin
                if (i_tx_done) begin
                    data_cnt_d = 8'd0;
                    state_d    = SEND_DATA;
                end
            end
            SEND_DATA: begin
                // Stall indefinitely on an empty buffer; frames are never padded.
                if (!fifo_empty && !i_tx_active) begin
                    tx_dv_d    = 1'b1;
                    tx_byte_d  = mem_q[rd_ptr_q];
                    pop        = 1'b1;
                    data_cnt_d = data_cnt_q + 8'd1;
                    state_d    = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (i_tx_done) begin
                    if (data_cnt_q == LAST_COUNT) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        state_d = SEND_DATA;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= IDLE;
            data_cnt_q   <= 8'd0;
            tx_dv_q      <= 1'b0;
            tx_byte_q    <= 8'h00;
            frame_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            data_cnt_q   <= data_cnt_d;
            tx_dv_q      <= tx_dv_d;
            tx_byte_q    <= tx_byte_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_tx_dv      = tx_dv_q;
    assign o_tx_byte    = tx_byte_q;
    assign o_frame_done = frame_done_q;
    assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: a small UART model answers each o_tx_dv
// with i_tx_done ten cycles later and records every transmitted byte.
module tb_uart_frame_tx;

    localparam int         FRAME_LEN  = 4;
    localparam int         FIFO_DEPTH = 8;
    localparam logic [7:0] HDR        = 8'hAA;
    localparam int         DONE_DELAY = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic [7:0] s_byte;
    logic       s_ready;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_active;
    logic       tx_done;
    logic       frame_done;
    logic       busy;
    logic       model_active;
    logic       hold_active;

    assign tx_active = model_active | hold_active;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;

    logic [7:0] sent[$];
    int         sent_cyc[$];
    int         frame_cnt    = 0;
    int         viol         = 0;
    int         frame_idx    = 0;
    int         delay_cnt    = 0;
    int         acc_total    = 0;
    int         pop_total    = 0;
    int         peak         = 0;
    int         sim_cnt      = 0;
    int         last_acc_cyc = -1;
    int         last_pop_cyc = -1;
    logic       act_seen     = 1'b0;
    logic       prev_dv      = 1'b0;
    logic       prev_fd      = 1'b0;
    logic [7:0] last_byte    = 8'h00;

    uart_frame_tx #(
        .HEADER_BYTE(HDR),
        .FRAME_LEN  (FRAME_LEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_s_valid   (s_valid),
        .i_s_byte    (s_byte),
        .o_s_ready   (s_ready),
        .o_tx_dv     (tx_dv),
        .o_tx_byte   (tx_byte),
        .i_tx_active (tx_active),
        .i_tx_done   (tx_done),
        .o_frame_done(frame_done),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        act_seen <= tx_active;
    end

    // UART model and protocol monitor, evaluated on the falling edge
    initial begin
        model_active = 1'b0;
        tx_done      = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_active = 1'b0;
                tx_done      = 1'b0;
                delay_cnt    = 0;
                frame_idx    = 0;
                prev_dv      = 1'b0;
                prev_fd      = 1'b0;
                last_byte    = 8'h00;
            end else begin
                if (tx_done) tx_done = 1'b0;
                if (delay_cnt > 0) begin
                    delay_cnt--;
                    if (delay_cnt == 0) begin
                        tx_done      = 1'b1;
                        model_active = 1'b0;
                    end
                end
                if (tx_dv) begin
                    if (act_seen || prev_dv) viol++;
                    sent.push_back(tx_byte);
                    sent_cyc.push_back(cyc);
                    if (frame_idx > 0) begin
                        pop_total++;
                        last_pop_cyc = cyc;
                    end
                    frame_idx++;
                    model_active = 1'b1;
                    delay_cnt    = DONE_DELAY;
                    last_byte    = tx_byte;
                end else if (tx_byte !== last_byte) begin
                    viol++;
                end
                if (frame_done) begin
                    if (prev_fd) viol++;
                    else frame_cnt++;
                    frame_idx = 0;
                end
                prev_dv = tx_dv;
                prev_fd = frame_done;
            end
        end
    end

    // Buffer occupancy and simultaneous push/pop tracking
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (acc_total - pop_total > peak) peak = acc_total - pop_total;
            if (last_acc_cyc == cyc && last_pop_cyc == cyc) sim_cnt++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    task automatic push(input logic [7:0] b, output int acc);
        int n;
        n       = 0;
        s_valid = 1'b1;
        s_byte  = b;
        while (!s_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            chk_cnt++;
            $display("[TB] FAIL push_timeout byte=%02h ready=%b required=1", b, s_ready);
            s_valid = 1'b0;
            acc     = -1;
        end else begin
            @(negedge clk);
            acc          = cyc;
            acc_total++;
            last_acc_cyc = cyc;
            s_valid      = 1'b0;
        end
    endtask

    task automatic wait_frames(input int target, output bit ok);
        int n;
        n = 0;
        while (frame_cnt < target && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        ok = (frame_cnt >= target);
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        s_valid      = 1'b0;
        s_byte       = 8'h00;
        hold_active  = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++; if (tx_dv !== 1'b0)      $display("[TB] FAIL reset_tx_dv got=%b want=0", tx_dv);           else pass_cnt++;
        chk_cnt++; if (tx_byte !== 8'h00)   $display("[TB] FAIL reset_tx_byte got=%02h want=00", tx_byte);    else pass_cnt++;
        chk_cnt++; if (frame_done !== 1'b0) $display("[TB] FAIL reset_frame_done got=%b want=0", frame_done); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0)       $display("[TB] FAIL reset_busy got=%b want=0", busy);             else pass_cnt++;
        chk_cnt++; if (s_ready !== 1'b1)    $display("[TB] FAIL reset_ready got=%b want=1", s_ready);         else pass_cnt++;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk_cnt++; if (sent.size() !== 0) $display("[TB] FAIL reset_idle_tx got=%0d bytes want=0", sent.size()); else pass_cnt++;
    endtask

    task automatic test_basic_frame();
        logic [7:0] exp [5];
        int acc0, a, base, c0;
        bit ok;
        exp = '{8'hAA, 8'h11, 8'h22, 8'h33, 8'h44};
        sent.delete();
        sent_cyc.delete();
        base = frame_cnt;
        push(8'h11, acc0);
        push(8'h22, a);
        push(8'h33, a);
        push(8'h44, a);
        wait_frames(base + 1, ok);
        chk_cnt++; if (ok !== 1'b1) $display("[TB] FAIL basic_frame_timeout got=%0d frames want=%0d", frame_cnt, base + 1); else pass_cnt++;
        repeat (20) @(negedge clk);
        chk_cnt++; if (frame_cnt !== base + 1) $display("[TB] FAIL basic_frame_pulses got=%0d want=%0d", frame_cnt - base, 1); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("[TB] FAIL basic_busy_after got=%b want=0", busy); else pass_cnt++;
        chk_cnt++; if (sent.size() !== 5) $display("[TB] FAIL basic_count got=%0d want=5", sent.size()); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            chk_cnt++;
            if (i >= sent.size() || sent[i] !== exp[i]) $display("[TB] FAIL basic_byte[%0d] got=%02h want=%02h", i, (i < sent.size()) ? sent[i] : 8'hxx, exp[i]);
            else pass_cnt++;
        end
        c0 = (sent_cyc.size() > 0) ? sent_cyc[0] : -1;
        chk_cnt++; if (c0 !== acc0 + 1) $display("[TB] FAIL header_latency got=cycle %0d want=cycle %0d", c0, acc0 + 1); else pass_cnt++;
    endtask

    task automatic test_header_data();
        logic [7:0] exp [5];
        int a, base;
        bit ok;
        exp = '{8'hAA, 8'hAA, 8'h55, 8'hAA, 8'h00};
        sent.delete();
        base = frame_cnt;
        push(8'hAA, a);
        push(8'h55, a);
        push(8'hAA, a);
        push(8'h00, a);
        wait_frames(base + 1, ok);
        chk_cnt++; if (ok !== 1'b1) $display("[TB] FAIL hdrdata_timeout got=%0d frames want=%0d", frame_cnt, base + 1); else pass_cnt++;
        chk_cnt++; if (sent.size() !== 5) $display("[TB] FAIL hdrdata_count got=%0d want=5", sent.size()); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            chk_cnt++;
            if (i >= sent.size() || sent[i] !== exp[i]) $display("[TB] FAIL hdrdata_byte[%0d] got=%02h want=%02h", i, (i < sent.size()) ? sent[i] : 8'hxx, exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_underrun();
        logic [7:0] exp [5];
        int a, base, n40;
        bit ok;
        exp = '{8'hAA, 8'h5A, 8'h5B, 8'h5C, 8'h5D};
        repeat (5) @(negedge clk);
        sent.delete();
        base = frame_cnt;
        push(8'h5A, a);
        repeat (40) @(negedge clk);
        n40 = sent.size();
        repeat (60) @(negedge clk);
        chk_cnt++; if (n40 !== 2) $display("[TB] FAIL underrun_sent_early got=%0d want=2", n40); else pass_cnt++;
        chk_cnt++; if (sent.size() !== 2) $display("[TB] FAIL underrun_gap_tx got=%0d want=2", sent.size()); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b1) $display("[TB] FAIL underrun_stall_busy got=%b want=1", busy); else pass_cnt++;
        push(8'h5B, a);
        push(8'h5C, a);
        push(8'h5D, a);
        wait_frames(base + 1, ok);
        chk_cnt++; if (ok !== 1'b1) $display("[TB] FAIL underrun_timeout got=%0d frames want=%0d", frame_cnt, base + 1); else pass_cnt++;
        chk_cnt++; if (sent.size() !== 5) $display("[TB] FAIL underrun_count got=%0d want=5", sent.size()); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            chk_cnt++;
            if (i >= sent.size() || sent[i] !== exp[i]) $display("[TB] FAIL underrun_byte[%0d] got=%02h want=%02h", i, (i < sent.size()) ? sent[i] : 8'hxx, exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_full_buffer();
        logic [7:0] exp [15];
        logic [7:0] nb;
        int a, acc9, base, c1;
        bit ok;
        nb = 8'h81;
        for (int i = 0; i < 15; i++) begin
            if (i % 5 == 0) exp[i] = HDR;
            else begin
                exp[i] = nb;
                nb     = nb + 8'h01;
            end
        end
        repeat (5) @(negedge clk);
        sent.delete();
        sent_cyc.delete();
        base        = frame_cnt;
        hold_active = 1'b1;
        for (int i = 0; i < 8; i++) push(8'h81 + 8'(i), a);
        chk_cnt++; if (s_ready !== 1'b0) $display("[TB] FAIL full_ready got=%b want=0", s_ready); else pass_cnt++;
        chk_cnt++; if (sent.size() !== 0) $display("[TB] FAIL full_tx_while_active got=%0d want=0", sent.size()); else pass_cnt++;
        fork
            push(8'h89, acc9);
            begin
                repeat (5) @(negedge clk);
                chk_cnt++; if (s_ready !== 1'b0) $display("[TB] FAIL full_ready_hold got=%b want=0", s_ready); else pass_cnt++;
                hold_active = 1'b0;
            end
        join
        c1 = (sent_cyc.size() > 1) ? sent_cyc[1] : -100;
        chk_cnt++; if (acc9 !== c1 + 1) $display("[TB] FAIL full_ninth_accept got=cycle %0d want=cycle %0d", acc9, c1 + 1); else pass_cnt++;
        push(8'h8A, a);
        push(8'h8B, a);
        push(8'h8C, a);
        wait_frames(base + 3, ok);
        chk_cnt++; if (ok !== 1'b1) $display("[TB] FAIL full_timeout got=%0d frames want=%0d", frame_cnt, base + 3); else pass_cnt++;
        chk_cnt++; if (sent.size() !== 15) $display("[TB] FAIL full_count got=%0d want=15", sent.size()); else pass_cnt++;
        for (int i = 0; i < 15; i++) begin
            chk_cnt++;
            if (i >= sent.size() || sent[i] !== exp[i]) $display("[TB] FAIL full_byte[%0d] got=%02h want=%02h", i, (i < sent.size()) ? sent[i] : 8'hxx, exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] exp [5];
        int a, base, n;
        bit ok;
        exp = '{8'hAA, 8'h10, 8'h11, 8'h12, 8'h13};
        repeat (5) @(negedge clk);
        sent.delete();
        base = frame_cnt;
        for (int i = 0; i < 4; i++) push(8'h01 + 8'(i), a);
        n = 0;
        while (sent.size() < 3 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk_cnt++; if (sent.size() < 3) $display("[TB] FAIL midrst_progress got=%0d bytes want=3", sent.size()); else pass_cnt++;
        rst = 1'b1;
        #1;
        chk_cnt++; if (tx_dv !== 1'b0)    $display("[TB] FAIL midrst_tx_dv got=%b want=0", tx_dv);          else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0)     $display("[TB] FAIL midrst_busy got=%b want=0", busy);            else pass_cnt++;
        chk_cnt++; if (s_ready !== 1'b1)  $display("[TB] FAIL midrst_ready got=%b want=1", s_ready);       else pass_cnt++;
        chk_cnt++; if (tx_byte !== 8'h00) $display("[TB] FAIL midrst_tx_byte got=%02h want=00", tx_byte);  else pass_cnt++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++; if (frame_cnt !== base) $display("[TB] FAIL midrst_no_frame_done got=%0d want=%0d", frame_cnt, base); else pass_cnt++;
        sent.delete();
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i), a);
        wait_frames(base + 1, ok);
        chk_cnt++; if (ok !== 1'b1) $display("[TB] FAIL midrst_timeout got=%0d frames want=%0d", frame_cnt, base + 1); else pass_cnt++;
        chk_cnt++; if (sent.size() !== 5) $display("[TB] FAIL midrst_count got=%0d want=5", sent.size()); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            chk_cnt++;
            if (i >= sent.size() || sent[i] !== exp[i]) $display("[TB] FAIL midrst_byte[%0d] got=%02h want=%02h", i, (i < sent.size()) ? sent[i] : 8'hxx, exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_pointer_wrap();
        logic [7:0] exp [25];
        logic [7:0] nb;
        int a, base, n;
        bit ok;
        nb = 8'h00;
        for (int i = 0; i < 25; i++) begin
            if (i % 5 == 0) exp[i] = HDR;
            else begin
                exp[i] = nb;
                nb     = nb + 8'h01;
            end
        end
        repeat (5) @(negedge clk);
        sent.delete();
        base      = frame_cnt;
        acc_total = 0;
        pop_total = 0;
        peak      = 0;
        sim_cnt   = 0;
        for (int k = 0; k < 4; k++) push(8'(k), a);
        // Each later push lands on the edge where the FSM pops after a done
        for (int k = 4; k < 20; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                #1;
                n++;
            end while (!tx_done && n < 200);
            if (!tx_done) begin
                chk_cnt++;
                $display("[TB] FAIL wrap_done_timeout got=%b want=1 byte=%0d", tx_done, k);
            end
            @(negedge clk);
            push(8'(k), a);
        end
        wait_frames(base + 5, ok);
        chk_cnt++; if (ok !== 1'b1) $display("[TB] FAIL wrap_timeout got=%0d frames want=%0d", frame_cnt, base + 5); else pass_cnt++;
        chk_cnt++; if (sent.size() !== 25) $display("[TB] FAIL wrap_count got=%0d want=25", sent.size()); else pass_cnt++;
        for (int i = 0; i < 25; i++) begin
            chk_cnt++;
            if (i >= sent.size() || sent[i] !== exp[i]) $display("[TB] FAIL wrap_byte[%0d] got=%02h want=%02h", i, (i < sent.size()) ? sent[i] : 8'hxx, exp[i]);
            else pass_cnt++;
        end
        chk_cnt++; if (peak > FIFO_DEPTH) $display("[TB] FAIL wrap_peak got=%0d want<=%0d", peak, FIFO_DEPTH); else pass_cnt++;
        chk_cnt++; if (sim_cnt < 1) $display("[TB] FAIL wrap_simultaneous got=%0d want>=1", sim_cnt); else pass_cnt++;
    endtask

    task automatic test_protocol();
        chk_cnt++; if (viol !== 0) $display("[TB] FAIL protocol_violations got=%0d want=0", viol); else pass_cnt++;
    endtask

    initial begin
        hold_active = 1'b0;
        rst         = 1'b1;
        s_valid     = 1'b0;
        s_byte      = 8'h00;
        test_reset();
        test_basic_frame();
        test_header_data();
        test_underrun();
        test_full_buffer();
        test_reset_midframe();
        test_pointer_wrap();
        test_protocol();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
